// File: rtl/deque_bank_if.sv
// Command/peek port of deque_bank: one command per clock, addressed by channel and end.
// The master drives commands; the slave (deque_bank) returns peek data and flag vectors.
interface deque_bank_if #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned WIDTH  = 8
);
  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [CH_W-1:0]   ch_sel;
  logic              end_sel;
  logic              push;
  logic              pop;
  logic [WIDTH-1:0]  data_in;
  logic [WIDTH-1:0]  data_out;
  logic [NUM_CH-1:0] empty;
  logic [NUM_CH-1:0] full;
  logic [1:0]        err;

  modport master (
    output ch_sel, end_sel, push, pop, data_in,
    input  data_out, empty, full, err
  );

  modport slave (
    input  ch_sel, end_sel, push, pop, data_in,
    output data_out, empty, full, err
  );
endinterface

// File: rtl/deque_bank.sv
// Bank of NUM_CH circular-buffer deques (head pointer + count) behind one command port.
// Define DEQUE_ERR_EN to build the sticky {overflow, underflow} error register.
module deque_bank #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned WIDTH  = 8
) (
  input logic         clk,
  input logic         rst_n,
  deque_bank_if.slave bus
);
  localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned PTR_W  = $clog2(DEPTH + 1);
  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W-1:0] PTR_FULL = PTR_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_ONE;
  endfunction

  function automatic logic [PTR_W-1:0] ptr_dec(input logic [PTR_W-1:0] p);
    return (p == '0) ? PTR_LAST : p - PTR_ONE;
  endfunction

  // head + count never exceeds 2*DEPTH-1, so a single conditional subtract wraps it.
  function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p,
                                                input logic [PTR_W-1:0] n);
    logic [PTR_W:0] sum;
    sum = {1'b0, p} + {1'b0, n};
    if (sum >= {1'b0, PTR_FULL}) begin
      sum = sum - {1'b0, PTR_FULL};
    end
    return sum[PTR_W-1:0];
  endfunction

  logic [WIDTH-1:0] mem_q   [NUM_CH][DEPTH];
  logic [PTR_W-1:0] head_q  [NUM_CH];
  logic [PTR_W-1:0] head_d  [NUM_CH];
  logic [PTR_W-1:0] count_q [NUM_CH];
  logic [PTR_W-1:0] count_d [NUM_CH];

  // Selected-channel view
  logic             sel_valid;
  logic [CH_W-1:0]  ch_idx;
  logic [PTR_W-1:0] cur_head;
  logic [PTR_W-1:0] cur_count;
  logic [PTR_W-1:0] tail_ptr;
  logic [PTR_W-1:0] back_ptr;
  logic [PTR_W-1:0] end_ptr;
  logic             cur_empty;
  logic             cur_full;

  assign sel_valid = (32'(bus.ch_sel) < NUM_CH);
  assign ch_idx    = sel_valid ? bus.ch_sel : '0;
  assign cur_head  = head_q[ch_idx];
  assign cur_count = count_q[ch_idx];
  assign cur_empty = (cur_count == '0);
  assign cur_full  = (cur_count == PTR_FULL);
  assign tail_ptr  = ptr_add(cur_head, cur_count);
  assign back_ptr  = ptr_dec(tail_ptr);
  assign end_ptr   = bus.end_sel ? back_ptr : cur_head;

  // Command decode; push+pop on an empty channel degrades to a plain push.
  logic do_replace;
  logic do_push;
  logic do_pop;

  always_comb begin
    do_replace = sel_valid && bus.push && bus.pop && !cur_empty;
    do_push    = sel_valid && bus.push && (!bus.pop || cur_empty) && !cur_full;
    do_pop     = sel_valid && bus.pop && !bus.push && !cur_empty;
  end

  logic             mem_we;
  logic [PTR_W-1:0] mem_waddr;

  always_comb begin
    head_d    = head_q;
    count_d   = count_q;
    mem_we    = 1'b0;
    mem_waddr = end_ptr;
    if (do_replace) begin
      mem_we = 1'b1;
    end else if (do_push) begin
      mem_we          = 1'b1;
      count_d[ch_idx] = cur_count + PTR_ONE;
      if (!bus.end_sel) begin
        head_d[ch_idx] = ptr_dec(cur_head);
        mem_waddr      = ptr_dec(cur_head);
      end else begin
        mem_waddr = tail_ptr;
      end
    end else if (do_pop) begin
      count_d[ch_idx] = cur_count - PTR_ONE;
      if (!bus.end_sel) begin
        head_d[ch_idx] = ptr_inc(cur_head);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NUM_CH); i++) begin
        head_q[i]  <= '0;
        count_q[i] <= '0;
      end
    end else begin
      head_q  <= head_d;
      count_q <= count_d;
    end
  end

  // Storage is deliberately left unreset; counts alone define validity.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[ch_idx][ADDR_W'(mem_waddr)] <= bus.data_in;
    end
  end

  always_comb begin
    bus.data_out = '0;
    if (sel_valid && !cur_empty) begin
      bus.data_out = mem_q[ch_idx][ADDR_W'(end_ptr)];
    end
  end

  always_comb begin
    bus.empty = '0;
    bus.full  = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      bus.empty[i] = (count_q[i] == '0);
      bus.full[i]  = (count_q[i] == PTR_FULL);
    end
  end

`ifdef DEQUE_ERR_EN
  logic       overflow;
  logic       underflow;
  logic       range_err;
  logic [1:0] err_q;
  logic [1:0] err_d;

  always_comb begin
    overflow  = sel_valid && bus.push && !bus.pop && cur_full;
    underflow = sel_valid && bus.pop && !bus.push && cur_empty;
    range_err = !sel_valid && (bus.push || bus.pop);
    err_d     = err_q | {overflow || range_err, underflow || range_err};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 2'b00;
    end else begin
      err_q <= err_d;
    end
  end

  assign bus.err = err_q;
`else
  assign bus.err = 2'b00;
`endif

endmodule

// File: tb/tb_deque_bank.sv
// Self-checking bench for deque_bank: directed steps on a 2x20 bank, then random
// mixed commands on a 3x7 bank compared against queue-based reference deques.
module tb_deque_bank;
  localparam int NA = 2;
  localparam int DA = 20;
  localparam int NB = 3;
  localparam int DB = 7;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  deque_bank_if #(.NUM_CH(NA), .WIDTH(8)) bus_a ();
  deque_bank_if #(.NUM_CH(NB), .WIDTH(8)) bus_b ();

  deque_bank #(.NUM_CH(NA), .DEPTH(DA), .WIDTH(8)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  deque_bank #(.NUM_CH(NB), .DEPTH(DB), .WIDTH(8)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  int n_cmp = 0;
  int n_mis = 0;

  // Reference deques: entries 0..NA-1 model dut_a, NA..NA+NB-1 model dut_b.
  logic [7:0] mq [NA+NB][$];
  logic [1:0] err_m [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int nch_of(input int d);
    return (d == 0) ? NA : NB;
  endfunction

  function automatic int base_of(input int d);
    return (d == 0) ? 0 : NA;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NA + NB; k++) mq[k].delete();
    err_m[0] = 2'b00;
    err_m[1] = 2'b00;
  endtask

  task automatic model_cmd(input int d, input int ch, input bit e, input bit pu, input bit po,
                           input logic [7:0] din);
    int k;
    int dep;
    dep = (d == 0) ? DA : DB;
    if (ch >= nch_of(d)) begin
      if (pu || po) err_m[d] = 2'b11;
      return;
    end
    k = base_of(d) + ch;
    if (pu && po && mq[k].size() != 0) begin
      if (e) mq[k][mq[k].size()-1] = din;
      else mq[k][0] = din;
    end else if (pu) begin
      if (mq[k].size() >= dep) err_m[d][1] = 1'b1;
      else if (e) mq[k].push_back(din);
      else mq[k].push_front(din);
    end else if (po) begin
      if (mq[k].size() == 0) err_m[d][0] = 1'b1;
      else if (e) void'(mq[k].pop_back());
      else void'(mq[k].pop_front());
    end
  endtask

  function automatic logic [7:0] peek(input int d, input int ch, input bit e);
    int k;
    if (ch >= nch_of(d)) return 8'h00;
    k = base_of(d) + ch;
    if (mq[k].size() == 0) return 8'h00;
    return e ? mq[k][mq[k].size()-1] : mq[k][0];
  endfunction

  function automatic logic [31:0] flags(input int d, input bit want_full);
    logic [31:0] v;
    int dep;
    v = '0;
    dep = (d == 0) ? DA : DB;
    for (int c = 0; c < nch_of(d); c++) begin
      v[c] = want_full ? (mq[base_of(d)+c].size() == dep) : (mq[base_of(d)+c].size() == 0);
    end
    return v;
  endfunction

  function automatic logic [31:0] exp_err(input int d);
`ifdef DEQUE_ERR_EN
    return {30'd0, err_m[d]};
`else
    return {30'd0, 2'b00 & err_m[d]};
`endif
  endfunction

  task automatic cmd_a(input int ch, input bit e, input bit pu, input bit po,
                       input logic [7:0] din);
    @(negedge clk);
    bus_a.ch_sel  = ch[0:0];
    bus_a.end_sel = e;
    bus_a.push    = pu;
    bus_a.pop     = po;
    bus_a.data_in = din;
    @(posedge clk);
    #1;
    bus_a.push = 1'b0;
    bus_a.pop  = 1'b0;
    model_cmd(0, ch, e, pu, po, din);
  endtask

  task automatic cmd_b(input int ch, input bit e, input bit pu, input bit po,
                       input logic [7:0] din);
    @(negedge clk);
    bus_b.ch_sel  = ch[1:0];
    bus_b.end_sel = e;
    bus_b.push    = pu;
    bus_b.pop     = po;
    bus_b.data_in = din;
    @(posedge clk);
    #1;
    bus_b.push = 1'b0;
    bus_b.pop  = 1'b0;
    model_cmd(1, ch, e, pu, po, din);
  endtask

  task automatic peek_a(input int ch, input bit e);
    bus_a.ch_sel  = ch[0:0];
    bus_a.end_sel = e;
    #1;
  endtask

  task automatic check_a(input string tag);
    for (int c = 0; c < NA; c++) begin
      for (int e = 0; e < 2; e++) begin
        peek_a(c, e[0]);
        chk($sformatf("%s.peek_ch%0d_end%0d", tag, c, e), {24'd0, bus_a.data_out},
            {24'd0, peek(0, c, e[0])});
      end
    end
    chk({tag, ".empty"}, {30'd0, bus_a.empty}, flags(0, 1'b0));
    chk({tag, ".full"}, {30'd0, bus_a.full}, flags(0, 1'b1));
    chk({tag, ".err"}, {30'd0, bus_a.err}, exp_err(0));
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int ch;
    int op;
    bit e;
    bit pu;
    bit po;
    logic [7:0] d;

    bus_a.ch_sel = '0; bus_a.end_sel = 1'b0; bus_a.push = 1'b0; bus_a.pop = 1'b0;
    bus_a.data_in = '0;
    bus_b.ch_sel = '0; bus_b.end_sel = 1'b0; bus_b.push = 1'b0; bus_b.pop = 1'b0;
    bus_b.data_in = '0;
    model_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_a("reset");
    chk("reset.b_empty", {29'd0, bus_b.empty}, 32'h7);
    chk("reset.b_full", {29'd0, bus_b.full}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Three push_back on ch0
    cmd_a(0, 1'b1, 1'b1, 1'b0, 8'h11);
    cmd_a(0, 1'b1, 1'b1, 1'b0, 8'h22);
    cmd_a(0, 1'b1, 1'b1, 1'b0, 8'h33);
    peek_a(0, 1'b0);
    chk("t1.front", {24'd0, bus_a.data_out}, 32'h11);
    peek_a(0, 1'b1);
    chk("t1.back", {24'd0, bus_a.data_out}, 32'h33);
    chk("t1.empty", {30'd0, bus_a.empty}, 32'h2);
    check_a("t1");

    // Fill ch1 from the front, then overflow
    for (int i = 0; i < DA; i++) cmd_a(1, 1'b0, 1'b1, 1'b0, 8'(i));
    chk("t2.full1", {31'd0, bus_a.full[1]}, 32'h1);
    peek_a(1, 1'b1);
    chk("t2.back", {24'd0, bus_a.data_out}, 32'h00);
    peek_a(1, 1'b0);
    chk("t2.front", {24'd0, bus_a.data_out}, 32'h13);
    cmd_a(1, 1'b0, 1'b1, 1'b0, 8'hEE);
    check_a("t2.drop");
`ifdef DEQUE_ERR_EN
    chk("t2.err_ovf", {30'd0, bus_a.err}, 32'h2);
`endif
    pulse_reset();
    check_a("t2.reset");

    // Pointer wrap on ch0
    for (int i = 0; i < 5; i++) cmd_a(0, 1'b1, 1'b1, 1'b0, 8'h30 + 8'(i));
    for (int i = 0; i < 4; i++) cmd_a(0, 1'b0, 1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 18; i++) cmd_a(0, 1'b1, 1'b1, 1'b0, 8'h40 + 8'(i));
    chk("t3.count", mq[0].size(), 32'd19);
    peek_a(0, 1'b0);
    chk("t3.front", {24'd0, bus_a.data_out}, 32'h34);
    peek_a(0, 1'b1);
    chk("t3.back", {24'd0, bus_a.data_out}, 32'h51);
    check_a("t3");
    for (int i = 0; i < 19; i++) begin
      cmd_a(0, 1'b0, 1'b0, 1'b1, 8'h00);
      peek_a(0, 1'b0);
      chk($sformatf("t3.drain%0d", i), {24'd0, bus_a.data_out}, {24'd0, peek(0, 0, 1'b0)});
    end
    check_a("t3.drained");
    pulse_reset();

    // Replace at the back; push+pop on an empty channel acts as push
    cmd_a(0, 1'b1, 1'b1, 1'b0, 8'h01);
    cmd_a(0, 1'b1, 1'b1, 1'b0, 8'h02);
    cmd_a(0, 1'b1, 1'b1, 1'b1, 8'hAA);
    peek_a(0, 1'b1);
    chk("t4.back", {24'd0, bus_a.data_out}, 32'hAA);
    peek_a(0, 1'b0);
    chk("t4.front", {24'd0, bus_a.data_out}, 32'h01);
    cmd_a(1, 1'b0, 1'b1, 1'b1, 8'h55);
    peek_a(1, 1'b0);
    chk("t4.ch1_peek", {24'd0, bus_a.data_out}, 32'h55);
    chk("t4.empty", {30'd0, bus_a.empty}, 32'h0);
    check_a("t4");

    // Underflow, then reset in the middle of a command
    cmd_a(1, 1'b1, 1'b0, 1'b1, 8'h00);
    cmd_a(1, 1'b0, 1'b0, 1'b1, 8'h00);
    chk("t5.empty1", {31'd0, bus_a.empty[1]}, 32'h1);
`ifdef DEQUE_ERR_EN
    chk("t5.err_udf", {30'd0, bus_a.err}, 32'h1);
`endif
    check_a("t5");
    @(negedge clk);
    bus_a.ch_sel = 1'b0; bus_a.end_sel = 1'b1; bus_a.push = 1'b1; bus_a.data_in = 8'h77;
    #2 rst_n = 1'b0;
    #1;
    chk("t5.async_empty", {30'd0, bus_a.empty}, 32'h3);
    chk("t5.async_err", {30'd0, bus_a.err}, 32'h0);
    model_reset();
    @(negedge clk);
    bus_a.push = 1'b0;
    rst_n = 1'b1;
    check_a("t5.after_reset");

    // Random mixed commands on the 3-channel, depth-7 bank
    for (int c = 0; c < 10000; c++) begin
      ch = $urandom_range(0, 3);
      e  = 1'($urandom_range(0, 1));
      op = $urandom_range(0, 9);
      pu = (op < 4) || (op == 8);
      po = ((op >= 4) && (op < 8)) || (op == 8);
      d  = 8'($urandom);
      cmd_b(ch, e, pu, po, d);
      chk("rnd.data", {24'd0, bus_b.data_out}, {24'd0, peek(1, ch, e)});
      chk("rnd.empty", {29'd0, bus_b.empty}, flags(1, 1'b0));
      chk("rnd.full", {29'd0, bus_b.full}, flags(1, 1'b1));
      chk("rnd.err", {30'd0, bus_b.err}, exp_err(1));
      ch = $urandom_range(0, 3);
      e  = 1'($urandom_range(0, 1));
      bus_b.ch_sel  = ch[1:0];
      bus_b.end_sel = e;
      #1;
      chk("rnd.peek", {24'd0, bus_b.data_out}, {24'd0, peek(1, ch, e)});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
